// File: rtl/rep_loop_counter_if.sv
// Control/status bundle between the microcode sequencer and the repeat/loop counter.
interface rep_loop_counter_if #(
  parameter int unsigned WIDTH = 16
);
  logic             load;
  logic [WIDTH-1:0] count_in;
  logic [1:0]       mode;
  logic             next;
  logic             zf;
  logic             suspend_req;
  logic             resume;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             suspended;
  logic             done;
  logic [1:0]       term_reason;

  modport master (
    output load, count_in, mode, next, zf, suspend_req, resume, abort,
    input  count, running, suspended, done, term_reason
  );

  modport slave (
    input  load, count_in, mode, next, zf, suspend_req, resume, abort,
    output count, running, suspended, done, term_reason
  );
endinterface

// File: rtl/rep_loop_counter.sv
// Iteration counter for REP/REPE/REPNE/LOOP sequences with flag termination,
// interrupt suspend/resume and a termination reason.
module rep_loop_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  rep_loop_counter_if.slave bus
);

  localparam int unsigned MODE_W   = 2;
  localparam int unsigned REASON_W = 2;

  localparam logic [MODE_W-1:0] MODE_REPE  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_REPNE = 2'b10;
  localparam logic [MODE_W-1:0] MODE_LOOP  = 2'b11;

  localparam logic [REASON_W-1:0] RSN_NONE  = 2'b00;
  localparam logic [REASON_W-1:0] RSN_COUNT = 2'b01;
  localparam logic [REASON_W-1:0] RSN_FLAG  = 2'b10;
  localparam logic [REASON_W-1:0] RSN_ABORT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_SUSP = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [REASON_W-1:0] reason_q, reason_d;
  logic                running_q, suspended_q, done_q;
  logic [WIDTH-1:0]    count_dec;

  assign count_dec = count_q - WIDTH'(1);

  // State, counter and status registers; status flags decode the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      mode_q      <= '0;
      reason_q    <= RSN_NONE;
      running_q   <= 1'b0;
      suspended_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      reason_q    <= reason_d;
      running_q   <= (state_d == ST_RUN);
      suspended_q <= (state_d == ST_SUSP);
      done_q      <= (state_d == ST_DONE);
    end
  end

  // Next state: load > abort > next > suspend_req/resume.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mode_d   = mode_q;
    reason_d = reason_q;

    if (bus.load) begin
      count_d  = bus.count_in;
      mode_d   = bus.mode;
      reason_d = RSN_NONE;
      if ((bus.mode != MODE_LOOP) && (bus.count_in == '0)) begin
        state_d  = ST_DONE;
        reason_d = RSN_COUNT;
      end else begin
        state_d = ST_RUN;
      end
    end else if (bus.abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      reason_d = RSN_ABORT;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.next) begin
            // Decrement always happens first; count exhaustion beats the flag test.
            count_d = count_dec;
            if (count_dec == '0) begin
              state_d  = ST_DONE;
              reason_d = RSN_COUNT;
            end else if ((mode_q == MODE_REPE) && !bus.zf) begin
              state_d  = ST_DONE;
              reason_d = RSN_FLAG;
            end else if ((mode_q == MODE_REPNE) && bus.zf) begin
              state_d  = ST_DONE;
              reason_d = RSN_FLAG;
            end else if (bus.suspend_req) begin
              state_d = ST_SUSP;
            end
          end else if (bus.suspend_req) begin
            state_d = ST_SUSP;
          end
        end
        ST_SUSP: begin
          if (bus.resume) begin
            state_d = ST_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.count       = count_q;
  assign bus.running     = running_q;
  assign bus.suspended   = suspended_q;
  assign bus.done        = done_q;
  assign bus.term_reason = reason_q;

endmodule

// File: tb/tb_rep_loop_counter.sv
// Directed testbench for rep_loop_counter; each step compares {count, running,
// suspended, done, term_reason} against hand-computed values.
module tb_rep_loop_counter;

  localparam int unsigned WIDTH = 16;

  // Status field {running, suspended, done, term_reason}
  localparam logic [4:0] S_IDLE   = 5'b00000;
  localparam logic [4:0] S_RUN    = 5'b10000;
  localparam logic [4:0] S_SUSP   = 5'b01000;
  localparam logic [4:0] S_DONE_C = 5'b00101;
  localparam logic [4:0] S_DONE_F = 5'b00110;
  localparam logic [4:0] S_ABORT  = 5'b00011;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [WIDTH+4:0] obs;

  rep_loop_counter_if #(.WIDTH(WIDTH)) bus ();

  rep_loop_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {bus.count, bus.running, bus.suspended, bus.done, bus.term_reason};

  task automatic clear_inputs();
    bus.load        = 1'b0;
    bus.next        = 1'b0;
    bus.zf          = 1'b0;
    bus.suspend_req = 1'b0;
    bus.resume      = 1'b0;
    bus.abort       = 1'b0;
  endtask

  // One clock with the currently driven inputs, then drop all pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_load(input logic [1:0] m, input logic [WIDTH-1:0] c);
    bus.load     = 1'b1;
    bus.mode     = m;
    bus.count_in = c;
    tick();
  endtask

  task automatic do_next(input logic z);
    bus.next = 1'b1;
    bus.zf   = z;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (obs !== {16'h0000, S_IDLE}) begin
      $display("FAIL reset: got %h expected %h", obs, {16'h0000, S_IDLE});
      errors++;
    end
    do_next(1'b0);
    checks++;
    if (obs !== {16'h0000, S_IDLE}) begin
      $display("FAIL idle_next_ignored: got %h expected %h", obs, {16'h0000, S_IDLE});
      errors++;
    end
  endtask

  task automatic test_rep_count();
    logic [WIDTH+4:0] exp_v [4];
    exp_v[0] = {16'd3, S_RUN};
    exp_v[1] = {16'd2, S_RUN};
    exp_v[2] = {16'd1, S_RUN};
    exp_v[3] = {16'd0, S_DONE_C};
    do_load(2'b00, 16'd3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== exp_v[i]) begin
        $display("FAIL rep_count step %0d: got %h expected %h", i, obs, exp_v[i]);
        errors++;
      end
      if (i < 3) begin
        tick();
        do_next(1'b1);
      end
    end
  endtask

  task automatic test_zero_precheck();
    do_load(2'b00, 16'd0);
    checks++;
    if (obs !== {16'd0, S_DONE_C}) begin
      $display("FAIL zero_precheck: got %h expected %h", obs, {16'd0, S_DONE_C});
      errors++;
    end
    do_next(1'b0);
    checks++;
    if (obs !== {16'd0, S_DONE_C}) begin
      $display("FAIL done_next_ignored: got %h expected %h", obs, {16'd0, S_DONE_C});
      errors++;
    end
  endtask

  task automatic test_flag_term();
    do_load(2'b01, 16'd5);
    do_next(1'b1);
    checks++;
    if (obs !== {16'd4, S_RUN}) begin
      $display("FAIL repe_continue: got %h expected %h", obs, {16'd4, S_RUN});
      errors++;
    end
    do_next(1'b0);
    checks++;
    if (obs !== {16'd3, S_DONE_F}) begin
      $display("FAIL repe_term: got %h expected %h", obs, {16'd3, S_DONE_F});
      errors++;
    end
    do_load(2'b10, 16'd5);
    do_next(1'b0);
    checks++;
    if (obs !== {16'd4, S_RUN}) begin
      $display("FAIL repne_continue: got %h expected %h", obs, {16'd4, S_RUN});
      errors++;
    end
    do_next(1'b1);
    checks++;
    if (obs !== {16'd3, S_DONE_F}) begin
      $display("FAIL repne_term: got %h expected %h", obs, {16'd3, S_DONE_F});
      errors++;
    end
    // Exhaustion and a failing flag together must report count termination.
    do_load(2'b01, 16'd1);
    do_next(1'b0);
    checks++;
    if (obs !== {16'd0, S_DONE_C}) begin
      $display("FAIL count_beats_flag: got %h expected %h", obs, {16'd0, S_DONE_C});
      errors++;
    end
  endtask

  task automatic test_loop_wrap();
    do_load(2'b11, 16'd0);
    checks++;
    if (obs !== {16'd0, S_RUN}) begin
      $display("FAIL loop_no_precheck: got %h expected %h", obs, {16'd0, S_RUN});
      errors++;
    end
    do_next(1'b0);
    checks++;
    if (obs !== {16'hFFFF, S_RUN}) begin
      $display("FAIL loop_wrap: got %h expected %h", obs, {16'hFFFF, S_RUN});
      errors++;
    end
    bus.abort = 1'b1;
    tick();
    checks++;
    if (obs !== {16'hFFFF, S_ABORT}) begin
      $display("FAIL abort_run: got %h expected %h", obs, {16'hFFFF, S_ABORT});
      errors++;
    end
    bus.abort = 1'b1;
    tick();
    checks++;
    if (obs !== {16'hFFFF, S_ABORT}) begin
      $display("FAIL abort_idle: got %h expected %h", obs, {16'hFFFF, S_ABORT});
      errors++;
    end
  endtask

  task automatic test_suspend_resume();
    do_load(2'b00, 16'd4);
    bus.suspend_req = 1'b1;
    tick();
    checks++;
    if (obs !== {16'd4, S_SUSP}) begin
      $display("FAIL suspend: got %h expected %h", obs, {16'd4, S_SUSP});
      errors++;
    end
    do_next(1'b0);
    checks++;
    if (obs !== {16'd4, S_SUSP}) begin
      $display("FAIL susp_next_ignored: got %h expected %h", obs, {16'd4, S_SUSP});
      errors++;
    end
    bus.resume = 1'b1;
    tick();
    checks++;
    if (obs !== {16'd4, S_RUN}) begin
      $display("FAIL resume: got %h expected %h", obs, {16'd4, S_RUN});
      errors++;
    end
    do_next(1'b0);
    checks++;
    if (obs !== {16'd3, S_RUN}) begin
      $display("FAIL resume_next: got %h expected %h", obs, {16'd3, S_RUN});
      errors++;
    end
    bus.next        = 1'b1;
    bus.suspend_req = 1'b1;
    tick();
    checks++;
    if (obs !== {16'd2, S_SUSP}) begin
      $display("FAIL next_then_suspend: got %h expected %h", obs, {16'd2, S_SUSP});
      errors++;
    end
    bus.abort = 1'b1;
    tick();
    checks++;
    if (obs !== {16'd2, S_ABORT}) begin
      $display("FAIL abort_susp: got %h expected %h", obs, {16'd2, S_ABORT});
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    do_load(2'b00, 16'd1);
    bus.next        = 1'b1;
    bus.suspend_req = 1'b1;
    tick();
    checks++;
    if (obs !== {16'd0, S_DONE_C}) begin
      $display("FAIL term_drops_suspend: got %h expected %h", obs, {16'd0, S_DONE_C});
      errors++;
    end
    bus.abort = 1'b1;
    tick();
    checks++;
    if (obs !== {16'd0, S_ABORT}) begin
      $display("FAIL abort_done: got %h expected %h", obs, {16'd0, S_ABORT});
      errors++;
    end
    bus.abort = 1'b1;
    do_load(2'b00, 16'd7);
    checks++;
    if (obs !== {16'd7, S_RUN}) begin
      $display("FAIL load_beats_abort: got %h expected %h", obs, {16'd7, S_RUN});
      errors++;
    end
    do_next(1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (obs !== {16'd0, S_IDLE}) begin
      $display("FAIL reset_mid_run: got %h expected %h", obs, {16'd0, S_IDLE});
      errors++;
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.mode     = 2'b00;
    bus.count_in = '0;
    clear_inputs();
    test_reset();
    test_rep_count();
    test_zero_precheck();
    test_flag_term();
    test_loop_wrap();
    test_suspend_resume();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
